mem_port_arbiter: RTL

//  Shares the single-port 8-bit program/data RAM between two requesters:

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Registered request/grant arbiter sharing one single-port synchronous RAM between port A and port B.
// Optional feature: define MEM_ARB_WPROTECT_EN to block port-A writes below PROT_TOP (prot_err pulses instead).

module mem_port_arbiter #(
    parameter int              AW       = 8,
    parameter int              DW       = 8,
    parameter int              PRIORITY = 0,
    parameter logic [AW-1:0]   PROT_TOP = 8'h10
) (
    input  logic          clock,
    input  logic          reset_N,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_adrs,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_adrs,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_adrs,
    output logic [DW-1:0] ram_data,
    output logic          ram_wr_en,
    input  logic [DW-1:0] ram_q,
    output logic          busy,
    output logic          owner,
    output logic          prot_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

`ifdef MEM_ARB_WPROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    logic [1:0]    state_r;
    logic [1:0]    state_nx_s;
    logic          win_b_r;
    logic          we_r;
    logic          last_b_r;
    logic          start_s;
    logic          pick_b_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_adrs_s;
    logic [DW-1:0] sel_wdata_s;
    logic          blk_s;

    function automatic logic prot_hit(input logic is_b, input logic we, input logic [AW-1:0] adrs);
        return PROT_EN && !is_b && we && (adrs < PROT_TOP);
    endfunction

    // Winner selection among the requests sampled in IDLE
    always_comb begin
        pick_b_s = 1'b0;
        case ({a_req, b_req})
            2'b10: pick_b_s = 1'b0;
            2'b01: pick_b_s = 1'b1;
            2'b11: begin
                if (PRIORITY == 1) begin
                    pick_b_s = 1'b0;
                end else if (PRIORITY == 2) begin
                    pick_b_s = 1'b1;
                end else begin
                    pick_b_s = ~last_b_r;
                end
            end
            default: pick_b_s = 1'b0;
        endcase
    end

    // Mux the winning request fields and flag protected writes
    always_comb begin
        start_s     = (state_r == ST_IDLE) && (a_req || b_req);
        sel_we_s    = pick_b_s ? b_we    : a_we;
        sel_adrs_s  = pick_b_s ? b_adrs  : a_adrs;
        sel_wdata_s = pick_b_s ? b_wdata : a_wdata;
        blk_s       = prot_hit(pick_b_s, sel_we_s, sel_adrs_s);
    end

    // Next-state logic for the IDLE/ISSUE/RESP schedule
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_r) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, latched access and all registered outputs; reset aborts any access in flight
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_r   <= ST_IDLE;
            win_b_r   <= 1'b0;
            we_r      <= 1'b0;
            last_b_r  <= 1'b1;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= {DW{1'b0}};
            b_rdata   <= {DW{1'b0}};
            ram_adrs  <= {AW{1'b0}};
            ram_data  <= {DW{1'b0}};
            ram_wr_en <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            prot_err  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            busy      <= (state_nx_s != ST_IDLE);
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            ram_wr_en <= 1'b0;
            prot_err  <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            if (start_s) begin
                win_b_r   <= pick_b_s;
                we_r      <= sel_we_s;
                ram_adrs  <= sel_adrs_s;
                ram_data  <= sel_wdata_s;
                ram_wr_en <= sel_we_s && !blk_s;
                prot_err  <= blk_s;
                a_gnt     <= !pick_b_s;
                b_gnt     <= pick_b_s;
                owner     <= pick_b_s;
                last_b_r  <= pick_b_s;
            end
            // RAM output is valid during RESP; capture it for the winner
            if (state_r == ST_RESP) begin
                if (win_b_r) begin
                    b_rdata  <= ram_q;
                    b_rvalid <= 1'b1;
                end else begin
                    a_rdata  <= ram_q;
                    a_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule
